// File: rtl/dds_lut_scheduler.sv
// Two-channel DDS scheduler sharing one sine LUT: lookups alternate A/B, and each result appears LUT_LAT+1 cycles after its issue.
// No backpressure; the LUT takes one lookup per cycle, and each channel's sample is held until its next result.
module dds_lut_scheduler #(
  parameter int ACC_W   = 32,
  parameter int LUT_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] ftw_a,
  input  logic [ACC_W-1:0] ftw_b,
  input  logic             ftw_load,
  input  logic             phase_clr,
  output logic             lut_enable,
  output logic [ACC_W-1:0] lut_phase,
  input  logic [7:0]       lut_sine,
  output logic [7:0]       sine_a,
  output logic [7:0]       sine_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc_a, acc_b, acc_a_nxt, acc_b_nxt;
  logic [ACC_W-1:0]   act_a, act_b, shd_a, shd_b, shd_a_nxt, shd_b_nxt;
  logic [LUT_LAT-1:0] tag_vld, tag_ch;
  logic               issuing, any_tag, apply_ftw;

  assign issuing = (state == ISSUE_A) || (state == ISSUE_B);
  assign any_tag = |tag_vld;
  assign busy    = issuing || any_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_a_nxt = acc_a;
    acc_b_nxt = acc_b;
    shd_a_nxt = ftw_load ? ftw_a : shd_a;
    shd_b_nxt = ftw_load ? ftw_b : shd_b;
    case (state)
      IDLE:    if (enable) state_nxt = ISSUE_A;
      ISSUE_A: state_nxt = ISSUE_B;
      ISSUE_B: state_nxt = enable ? ISSUE_A : DRAIN;
      DRAIN: begin
        if (enable)        state_nxt = ISSUE_A;
        else if (!any_tag) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Clearing wins over the increment of the lookup being issued now.
    if (phase_clr) begin
      acc_a_nxt = '0;
      acc_b_nxt = '0;
    end else if (state == ISSUE_A) begin
      acc_a_nxt = acc_a + act_a;
    end else if (state == ISSUE_B) begin
      acc_b_nxt = acc_b + act_b;
    end
    // New tuning words only take effect at a pair boundary, or at once when idle.
    apply_ftw = (state_nxt == ISSUE_A) || (state == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_a      <= '0;
      acc_b      <= '0;
      act_a      <= '0;
      act_b      <= '0;
      shd_a      <= '0;
      shd_b      <= '0;
      lut_enable <= 1'b0;
      lut_phase  <= '0;
    end else begin
      acc_a <= acc_a_nxt;
      acc_b <= acc_b_nxt;
      shd_a <= shd_a_nxt;
      shd_b <= shd_b_nxt;
      if (apply_ftw) begin
        act_a <= shd_a_nxt;
        act_b <= shd_b_nxt;
      end
      if (state_nxt == ISSUE_A) begin
        lut_enable <= 1'b1;
        lut_phase  <= acc_a_nxt;
      end else if (state_nxt == ISSUE_B) begin
        lut_enable <= 1'b1;
        lut_phase  <= acc_b_nxt;
      end else begin
        lut_enable <= 1'b0;
      end
    end
  end

  // Bit LUT_LAT-1 of the tag pipe lines up with lut_sine for that lookup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      tag_ch  <= '0;
      sine_a  <= '0;
      sine_b  <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      tag_vld <= phase_clr ? '0 : ((tag_vld << 1) | LUT_LAT'(issuing));
      tag_ch  <= (tag_ch << 1) | LUT_LAT'(state == ISSUE_B);
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      if (tag_vld[LUT_LAT-1] && !phase_clr) begin
        if (tag_ch[LUT_LAT-1]) begin
          sine_b  <= lut_sine;
          valid_b <= 1'b1;
        end else begin
          sine_a  <= lut_sine;
          valid_a <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_lut_scheduler.sv
// Randomized bench for dds_lut_scheduler against a queue-based reference model, plus directed phase/latency checks.
module tb_dds_lut_scheduler;
  localparam int AW  = 32;
  localparam int LAT = 2;
  localparam int M_IDLE = 0, M_A = 1, M_B = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0, ftw_load = 1'b0, phase_clr = 1'b0;
  logic [AW-1:0] ftw_a = '0, ftw_b = '0;
  logic          lut_enable;
  logic [AW-1:0] lut_phase;
  logic [7:0]    lut_sine = 8'h00;
  logic [7:0]    sine_a, sine_b;
  logic          valid_a, valid_b, busy;

  always #5 clk = ~clk;

  dds_lut_scheduler #(.ACC_W(AW), .LUT_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ftw_a(ftw_a), .ftw_b(ftw_b),
    .ftw_load(ftw_load), .phase_clr(phase_clr), .lut_enable(lut_enable),
    .lut_phase(lut_phase), .lut_sine(lut_sine), .sine_a(sine_a), .sine_b(sine_b),
    .valid_a(valid_a), .valid_b(valid_b), .busy(busy)
  );

  int n_vec = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sine_of(input logic [7:0] p);
    return {p[3:0], p[7:4]} ^ 8'hA5;
  endfunction

  // Behavioural LUT: answers LAT cycles after a lookup, garbage otherwise.
  logic [8:0] hist [0:LAT];
  initial for (int i = 0; i <= LAT; i++) hist[i] = '0;
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {lut_enable, lut_phase[AW-1:AW-8]};
    lut_sine = hist[LAT][8] ? sine_of(hist[LAT][7:0]) : 8'($urandom);
  end

  // Reference model: pending results are a queue of (cycle due, channel).
  typedef struct { int due; int ch; } res_t;
  res_t          m_q[$];
  int            m_mode, m_cyc;
  logic [AW-1:0] m_acc[2], m_act[2], m_shd[2], m_phase;
  logic          m_en;
  logic [7:0]    m_sine[2];
  logic          m_valid[2];

  task automatic m_reset();
    m_q.delete();
    m_mode = M_IDLE; m_cyc = 0; m_phase = '0; m_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = '0; m_act[c] = '0; m_shd[c] = '0; m_sine[c] = '0; m_valid[c] = 1'b0;
    end
  endtask

  task automatic m_step();
    bit iss, pend;
    int ch, nxt;
    iss  = (m_mode == M_A) || (m_mode == M_B);
    ch   = (m_mode == M_B) ? 1 : 0;
    pend = (m_q.size() != 0);
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    if (pend && m_q[0].due == m_cyc) begin
      if (!phase_clr) begin
        m_sine[m_q[0].ch]  = lut_sine;
        m_valid[m_q[0].ch] = 1'b1;
      end
      void'(m_q.pop_front());
    end
    if (phase_clr) m_q.delete();
    else if (iss) m_q.push_back('{due: m_cyc + LAT, ch: ch});
    if (phase_clr) begin m_acc[0] = '0; m_acc[1] = '0; end
    else if (iss) m_acc[ch] = m_acc[ch] + m_act[ch];
    if (ftw_load) begin m_shd[0] = ftw_a; m_shd[1] = ftw_b; end
    case (m_mode)
      M_IDLE:  nxt = enable ? M_A : M_IDLE;
      M_A:     nxt = M_B;
      M_B:     nxt = enable ? M_A : M_DRAIN;
      default: nxt = enable ? M_A : (pend ? M_DRAIN : M_IDLE);
    endcase
    if (nxt == M_A || m_mode == M_IDLE) begin m_act[0] = m_shd[0]; m_act[1] = m_shd[1]; end
    m_en = (nxt == M_A) || (nxt == M_B);
    if (nxt == M_A) m_phase = m_acc[0];
    else if (nxt == M_B) m_phase = m_acc[1];
    m_mode = nxt;
    m_cyc++;
  endtask

  always @(posedge clk) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  // Directed-test observation logs, cleared on every reset.
  logic [AW-1:0] phase_log[$];
  int first_en, first_va, first_v, last_vb, last_busy;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("lut_enable", lut_enable, m_en);
      chk("lut_phase",  lut_phase,  m_phase);
      chk("sine_a",     sine_a,     m_sine[0]);
      chk("sine_b",     sine_b,     m_sine[1]);
      chk("valid_a",    valid_a,    m_valid[0]);
      chk("valid_b",    valid_b,    m_valid[1]);
      chk("busy",       busy, (m_mode == M_A || m_mode == M_B || m_q.size() != 0));
      chk("valid_excl", valid_a & valid_b, 0);
      if (reset_n) begin
        if (lut_enable) phase_log.push_back(lut_phase);
        if (lut_enable && first_en < 0) first_en = m_cyc;
        if (valid_a && first_va < 0) first_va = m_cyc;
        if ((valid_a || valid_b) && first_v < 0) first_v = m_cyc;
        if (valid_b) last_vb = m_cyc;
        if (busy) last_busy = m_cyc;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0; enable = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0;
    m_reset();
    phase_log.delete();
    first_en = -1; first_va = -1; first_v = -1; last_vb = -1; last_busy = -1;
    #1;
    chk("rst_lut_enable", lut_enable, 0);
    chk("rst_lut_phase",  lut_phase,  0);
    chk("rst_sine",       {sine_a, sine_b}, 0);
    chk("rst_valid",      {valid_a, valid_b}, 0);
    chk("rst_busy",       busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic tick(input bit en, input bit ld, input bit clr);
    enable = en; ftw_load = ld; phase_clr = clr;
    @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [AW-1:0] exp);
    chk(name, (idx < phase_log.size()) ? {32'h0, phase_log[idx]} : 64'hDEAD_0000_0000, exp);
  endtask

  task automatic run_wrap(input logic [AW-1:0] fa, input logic [AW-1:0] e0,
                          input logic [AW-1:0] e1, input logic [AW-1:0] e2);
    do_reset();
    ftw_a = fa; ftw_b = 32'h0;
    tick(1, 1, 0);
    repeat (7) tick(1, 0, 0);
    chk_log("wrap_a0", 0, e0);
    chk_log("wrap_a1", 2, e1);
    chk_log("wrap_a2", 4, e2);
    repeat (LAT + 4) tick(0, 0, 0);
  endtask

  logic [AW-1:0] exp_seq[8];

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_on = 1'b1;

    // Basic pair sequence and first-result latency.
    do_reset();
    ftw_a = 32'h0100_0000; ftw_b = 32'h0200_0000;
    tick(1, 1, 0);
    repeat (8) tick(1, 0, 0);
    exp_seq = '{32'h0, 32'h0, 32'h0100_0000, 32'h0200_0000, 32'h0200_0000, 32'h0400_0000, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) chk_log("basic_phase", i, exp_seq[i]);
    chk("first_valid_a_latency", first_va - first_en, LAT + 1);
    repeat (LAT + 4) tick(0, 0, 0);

    // Accumulator wrap.
    run_wrap(32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0);
    run_wrap(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Tuning-word load during an ISSUE_B cycle applies from the next ISSUE_A.
    do_reset();
    ftw_a = 32'h100; ftw_b = 32'h1000;
    tick(1, 1, 0);
    repeat (3) tick(1, 0, 0);
    ftw_a = 32'h1_0000; ftw_b = 32'h10_0000;
    tick(1, 1, 0);
    repeat (6) tick(1, 0, 0);
    exp_seq = '{32'h0, 32'h0, 32'h100, 32'h1000, 32'h200, 32'h2000, 32'h1_0200, 32'h10_2000};
    for (int i = 0; i < 8; i++) chk_log("ftw_pair_phase", i, exp_seq[i]);
    repeat (LAT + 4) tick(0, 0, 0);

    // phase_clr during ISSUE_A discards everything in flight.
    do_reset();
    ftw_a = 32'h100; ftw_b = 32'h1000;
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 1);
    repeat (LAT + 5) tick(1, 0, 0);
    chk_log("clr_phase_b", 3, 32'h0);
    chk_log("clr_phase_a", 4, 32'h0);
    chk_log("clr_phase_b2", 5, 32'h1000);
    chk("clr_first_valid", first_v, LAT + 5);
    chk("clr_first_valid_a", first_va, LAT + 6);
    repeat (LAT + 4) tick(0, 0, 0);

    // Enable dropped in ISSUE_A: B still issues, drain completes, then idle.
    do_reset();
    ftw_a = 32'h300; ftw_b = 32'h500;
    tick(1, 1, 0);
    repeat (LAT + 6) tick(0, 0, 0);
    chk("drain_issue_count", phase_log.size(), 2);
    chk("drain_last_valid_b", last_vb, LAT + 3);
    chk("drain_last_busy", last_busy, LAT + 2);
    chk("drain_idle_busy", busy, 0);

    // Randomized run with occasional mid-run resets.
    begin
      bit en_r, ld, clr;
      en_r = 1'b1;
      for (int it = 0; it < 3000; it++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
          continue;
        end
        if ($urandom_range(0, 4) == 0) en_r = ~en_r;
        ld  = ($urandom_range(0, 9) == 0);
        clr = ($urandom_range(0, 19) == 0);
        if (ld) begin
          ftw_a = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h00FF_FFFF);
          ftw_b = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h00FF_FFFF);
        end
        tick(en_r, ld, clr);
      end
      repeat (LAT + 6) tick(0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
